duty_ramp_limiter: RTL

DUTY_RAMP_LIMITER -- requirements
Module: duty_ramp_limiter

---
 rtl/duty_ramp_limiter.sv | 132 +++++++++++++
 1 files changed

// File: rtl/duty_ramp_limiter.sv
// Slew-rate limiter for a PWM duty code: moves duty toward an accepted target by at most STEP per tick.
// Optional macro DUTY_RAMP_FAST_DOWN_EN: RAMP_DOWN jumps straight to the target on its first tick.
module duty_ramp_limiter #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STEP   = 1,
  parameter int unsigned PERIOD = 256
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] target,
  input  logic             target_valid,
  output logic             target_ready,
  output logic [WIDTH-1:0] duty,
  output logic             ramping,
  output logic             at_target
);

  localparam int unsigned CW = $clog2(PERIOD);
  localparam int unsigned DW = WIDTH + 1;
  localparam logic [DW-1:0] STEP_W   = DW'(STEP);
  localparam logic [CW-1:0] CNT_LAST = CW'(PERIOD - 1);

  typedef enum logic [1:0] {IDLE, HOLD, RAMP_UP, RAMP_DOWN} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] duty_q, duty_d;
  logic [WIDTH-1:0] target_q, target_d;
  logic             ramping_q, at_target_q;
  logic             tick;
  logic             accept;
  logic [DW-1:0]    up_sum;
`ifndef DUTY_RAMP_FAST_DOWN_EN
  logic [DW-1:0]    down_gap;
`endif

  assign tick         = (cnt_q == CNT_LAST);
  assign target_ready = enable && (state_q == HOLD);
  assign accept       = target_valid && target_ready;
  assign up_sum       = {1'b0, duty_q} + STEP_W;
`ifndef DUTY_RAMP_FAST_DOWN_EN
  assign down_gap     = {1'b0, duty_q} - {1'b0, target_q};
`endif

  // Tick counter: parked at zero while disabled
  always_comb begin
    cnt_d = '0;
    if (enable) begin
      cnt_d = tick ? '0 : cnt_q + CW'(1);
    end
  end

  // Next-state and duty update; disable overrides ticks and accepts
  always_comb begin
    state_d  = state_q;
    duty_d   = duty_q;
    target_d = target_q;
    unique case (state_q)
      IDLE: begin
        state_d = HOLD;
        duty_d  = '0;
      end
      HOLD: begin
        if (accept) begin
          target_d = target;
          if (target > duty_q) begin
            state_d = RAMP_UP;
          end else if (target < duty_q) begin
            state_d = RAMP_DOWN;
          end
        end
      end
      RAMP_UP: begin
        if (tick) begin
          // Sum carries an extra bit so a large STEP cannot wrap past the target
          if (up_sum >= {1'b0, target_q}) begin
            duty_d  = target_q;
            state_d = HOLD;
          end else begin
            duty_d = up_sum[WIDTH-1:0];
          end
        end
      end
      RAMP_DOWN: begin
        if (tick) begin
`ifdef DUTY_RAMP_FAST_DOWN_EN
          duty_d  = target_q;
          state_d = HOLD;
`else
          if (down_gap <= STEP_W) begin
            duty_d  = target_q;
            state_d = HOLD;
          end else begin
            duty_d = duty_q - STEP_W[WIDTH-1:0];
          end
`endif
        end
      end
      default: state_d = IDLE;
    endcase
    if (!enable) begin
      state_d  = IDLE;
      duty_d   = '0;
      target_d = '0;
    end
  end

  // State and datapath registers; status flags track the next state
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      duty_q      <= '0;
      target_q    <= '0;
      ramping_q   <= 1'b0;
      at_target_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      duty_q      <= duty_d;
      target_q    <= target_d;
      ramping_q   <= (state_d == RAMP_UP) || (state_d == RAMP_DOWN);
      at_target_q <= (state_d == HOLD);
    end
  end

  assign duty      = duty_q;
  assign ramping   = ramping_q;
  assign at_target = at_target_q;

endmodule
